// File: rtl/ro_puf_if.sv
// Handshake bundle between the PUF controller and its requester:
// start/challenge/window in, busy/done/response/tie count out.
interface ro_puf_if #(
    parameter int WIN_W  = 16,
    parameter int RESP_W = 8
);
    localparam int TIE_W = $clog2(RESP_W + 1);

    logic              start;
    logic [15:0]       challenge;
    logic [WIN_W-1:0]  window_len;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] response;
    logic [TIE_W-1:0]  tie_cnt;

    modport master (
        output start, challenge, window_len,
        input  busy, done, response, tie_cnt
    );

    modport slave (
        input  start, challenge, window_len,
        output busy, done, response, tie_cnt
    );
endinterface

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: per response bit, enables an LFSR-chosen
// oscillator pair, counts synchronised edges over a window and compares them.
module ro_puf_ctrl #(
    parameter int NUM_RO = 16,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int RESP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] osc_en,
    ro_puf_if.slave           bus
);
    localparam int SEL_W = $clog2(NUM_RO);
    localparam int TIE_W = $clog2(RESP_W + 1);
    localparam int K_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        if (s[0]) begin
            return (s >> 1) ^ 16'hB400;
        end else begin
            return s >> 1;
        end
    endfunction

    // Returns {idx_b, idx_a}; a coincident pair is split by flipping the LSB.
    function automatic logic [2*SEL_W-1:0] pair_sel(input logic [15:0] s);
        logic [SEL_W-1:0] a;
        logic [SEL_W-1:0] b;
        a = s[SEL_W-1:0];
        b = s[2*SEL_W-1:SEL_W];
        if (b == a) begin
            b = a ^ SEL_W'(1);
        end else begin
            b = b;
        end
        return {b, a};
    endfunction

    state_t              state_r, state_s;
    logic [15:0]         lfsr_r, lfsr_s;
    logic [WIN_W-1:0]    win_r, win_s;
    logic [WIN_W-1:0]    timer_r, timer_s;
    logic [K_W-1:0]      k_r, k_s;
    logic [TIE_W-1:0]    tie_r, tie_s;
    logic [RESP_W-1:0]   resp_r, resp_s;
    logic [2*SEL_W-1:0]  pair_s;
    logic [SEL_W-1:0]    idx_a_r, idx_b_r;
    logic [NUM_RO-1:0]   osc_en_r, osc_en_s;
    logic                busy_r, done_r;
    logic [2:0]          sync_a_r, sync_b_r;
    logic                rise_a_s, rise_b_s;
    logic [CNT_W-1:0]    cnt_a_r, cnt_b_r;

    assign rise_a_s = sync_a_r[1] & ~sync_a_r[2];
    assign rise_b_s = sync_b_r[1] & ~sync_b_r[2];

    // Next-state and datapath update for the evaluation sequence.
    always_comb begin
        state_s = state_r;
        lfsr_s  = lfsr_r;
        win_s   = win_r;
        timer_s = timer_r;
        k_s     = k_r;
        tie_s   = tie_r;
        resp_s  = resp_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SETTLE;
                    lfsr_s  = (bus.challenge == 16'h0000) ? 16'h0001 : bus.challenge;
                    win_s   = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
                    timer_s = '0;
                    k_s     = '0;
                    tie_s   = '0;
                    resp_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_r == WIN_W'(2)) begin
                    state_s = ST_MEASURE;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + WIN_W'(1);
                end
            end
            ST_MEASURE: begin
                if (timer_r == (win_r - WIN_W'(1))) begin
                    state_s = ST_COMPARE;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + WIN_W'(1);
                end
            end
            ST_COMPARE: begin
                if (cnt_a_r == cnt_b_r) begin
                    resp_s[k_r] = 1'b0;
                    tie_s       = tie_r + TIE_W'(1);
                end else begin
                    resp_s[k_r] = (cnt_a_r > cnt_b_r);
                end
                lfsr_s  = lfsr_step(lfsr_r);
                k_s     = k_r + K_W'(1);
                timer_s = '0;
                if (k_r == K_W'(RESP_W - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Oscillator enables follow the pair of the LFSR value the next cycle will use.
    always_comb begin
        pair_s   = pair_sel(lfsr_s);
        osc_en_s = '0;
        if ((state_s == ST_SETTLE) || (state_s == ST_MEASURE)) begin
            osc_en_s[pair_s[SEL_W-1:0]]       = 1'b1;
            osc_en_s[pair_s[2*SEL_W-1:SEL_W]] = 1'b1;
        end else begin
            osc_en_s = '0;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= 16'h0001;
            win_r    <= '0;
            timer_r  <= '0;
            k_r      <= '0;
            tie_r    <= '0;
            resp_r   <= '0;
            idx_a_r  <= '0;
            idx_b_r  <= '0;
            osc_en_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            lfsr_r   <= lfsr_s;
            win_r    <= win_s;
            timer_r  <= timer_s;
            k_r      <= k_s;
            tie_r    <= tie_s;
            resp_r   <= resp_s;
            idx_a_r  <= pair_s[SEL_W-1:0];
            idx_b_r  <= pair_s[2*SEL_W-1:SEL_W];
            osc_en_r <= osc_en_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_DONE);
        end
    end

    // Two-flop synchronisers plus edge-detect flop on the selected oscillators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a_r <= 3'b000;
            sync_b_r <= 3'b000;
        end else begin
            sync_a_r <= {sync_a_r[1:0], ro_in[idx_a_r]};
            sync_b_r <= {sync_b_r[1:0], ro_in[idx_b_r]};
        end
    end

    // Saturating edge counters, cleared while the synchronisers flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
        end else if (state_r == ST_SETTLE) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
        end else if (state_r == ST_MEASURE) begin
            if (rise_a_s && (cnt_a_r != '1)) begin
                cnt_a_r <= cnt_a_r + CNT_W'(1);
            end
            if (rise_b_s && (cnt_b_r != '1)) begin
                cnt_b_r <= cnt_b_r + CNT_W'(1);
            end
        end
    end

    assign osc_en       = osc_en_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.response = resp_r;
    assign bus.tie_cnt  = tie_r;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl against a challenge-level reference model.
module tb_ro_puf_ctrl;
    localparam int RESP_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ro_in = 16'h0000;
    logic [15:0] osc_en1, osc_en2;
    logic        use_sat = 1'b0;
    int          ro_mode = 0;
    int          ro_cnt [16];
    int          total = 0;
    int          bad = 0;
    int          exp_a [RESP_W];
    int          exp_b [RESP_W];
    logic [15:0] exp_mask [RESP_W];

    always #5 clk = ~clk;

    ro_puf_if #(.WIN_W(16), .RESP_W(RESP_W)) bus1 ();
    ro_puf_if #(.WIN_W(16), .RESP_W(RESP_W)) bus2 ();

    ro_puf_ctrl #(.NUM_RO(16), .CNT_W(16), .WIN_W(16), .RESP_W(RESP_W)) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .osc_en(osc_en1), .bus(bus1.slave));
    ro_puf_ctrl #(.NUM_RO(16), .CNT_W(4), .WIN_W(16), .RESP_W(RESP_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .osc_en(osc_en2), .bus(bus2.slave));

    logic [15:0] cur_osc;
    logic        cur_busy, cur_done;
    logic [7:0]  cur_resp;
    logic [3:0]  cur_tie;
    assign cur_osc  = use_sat ? osc_en2 : osc_en1;
    assign cur_busy = use_sat ? bus2.busy : bus1.busy;
    assign cur_done = use_sat ? bus2.done : bus1.done;
    assign cur_resp = use_sat ? bus2.response : bus1.response;
    assign cur_tie  = use_sat ? bus2.tie_cnt : bus1.tie_cnt;

    // Oscillator bank model: mode 0 silent, 1 = line i toggles every i+2 cycles, 2 = all every 2.
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) begin
            int per;
            per = (ro_mode == 2) ? 2 : (i + 2);
            if (ro_mode == 0) begin
                ro_in[i]  = 1'b0;
                ro_cnt[i] = 0;
            end else begin
                ro_cnt[i] = ro_cnt[i] + 1;
                if (ro_cnt[i] >= per) begin
                    ro_cnt[i] = 0;
                    ro_in[i]  = ~ro_in[i];
                end
            end
        end
    end

    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [7:0] ordered_resp();
        logic [7:0] r;
        for (int k = 0; k < RESP_W; k++) r[k] = (exp_a[k] < exp_b[k]);
        return r;
    endfunction

    task automatic set_start(input logic v);
        bus1.start = v & ~use_sat;
        bus2.start = v & use_sat;
    endtask

    // Runs one evaluation and records what was seen; the test tasks judge it.
    task automatic do_eval(input logic [15:0] ch, input int wl, input int mid_j,
                           output int done_j, output int osc_bad, output int busy_bad,
                           output logic [7:0] resp, output logic [3:0] ties);
        int weff, tot;
        logic [15:0] s;
        weff = (wl == 0) ? 1 : wl;
        tot  = RESP_W * (weff + 4);
        s    = (ch == 16'h0000) ? 16'h0001 : ch;
        for (int k = 0; k < RESP_W; k++) begin
            exp_a[k] = int'(s[3:0]);
            exp_b[k] = int'(s[7:4]);
            if (exp_b[k] == exp_a[k]) exp_b[k] = exp_a[k] ^ 1;
            exp_mask[k] = (16'h0001 << exp_a[k]) | (16'h0001 << exp_b[k]);
            s = step(s);
        end
        done_j = -1; osc_bad = 0; busy_bad = 0; resp = 8'h00; ties = 4'h0;
        @(negedge clk);
        bus1.challenge = ch; bus2.challenge = ch;
        bus1.window_len = wl[15:0]; bus2.window_len = wl[15:0];
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int j = 0; j <= tot + 10; j++) begin
            logic [15:0] em;
            if ((j < tot) && ((j % (weff + 4)) < (weff + 3))) em = exp_mask[j / (weff + 4)];
            else em = 16'h0000;
            if (cur_osc !== em) osc_bad++;
            if (cur_busy !== (j <= tot)) busy_bad++;
            if ((cur_done === 1'b1) && (done_j < 0)) begin
                done_j = j; resp = cur_resp; ties = cur_tie;
            end
            if (j == mid_j) begin
                bus1.challenge = ~ch; bus2.challenge = ~ch;
                bus1.window_len = 16'd3; bus2.window_len = 16'd3;
                set_start(1'b1);
            end else begin
                set_start(1'b0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.start = 1'b1; bus2.start = 1'b1;
        bus1.challenge = 16'h0; bus2.challenge = 16'h0;
        bus1.window_len = 16'd0; bus2.window_len = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus1.busy); end
        total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus1.done); end
        total++; if (bus1.response !== 8'h00) begin bad++; $display("FAIL reset_resp got=%h exp=00", bus1.response); end
        total++; if (bus1.tie_cnt !== 4'h0) begin bad++; $display("FAIL reset_tie got=%0d exp=0", bus1.tie_cnt); end
        total++; if (osc_en1 !== 16'h0000) begin bad++; $display("FAIL reset_osc got=%h exp=0000", osc_en1); end
        bus1.start = 1'b0; bus2.start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", bus1.busy); end
    endtask

    task automatic test_all_ties();
        int dj, ob, bb; logic [7:0] r; logic [3:0] t;
        use_sat = 1'b0; ro_mode = 0;
        do_eval(16'h1234, 50, -1, dj, ob, bb, r, t);
        total++; if (dj !== 432) begin bad++; $display("FAIL ties_done_cycle got=%0d exp=432", dj); end
        total++; if (r !== 8'h00) begin bad++; $display("FAIL ties_resp got=%h exp=00", r); end
        total++; if (t !== 4'd8) begin bad++; $display("FAIL ties_cnt got=%0d exp=8", t); end
        total++; if (ob !== 0) begin bad++; $display("FAIL ties_osc_en bad_cycles=%0d exp=0", ob); end
        total++; if (bb !== 0) begin bad++; $display("FAIL ties_busy bad_cycles=%0d exp=0", bb); end
    endtask

    task automatic check_ordered(input logic [15:0] ch, input int wl, input int mid_j);
        int dj, ob, bb; logic [7:0] r, er; logic [3:0] t;
        use_sat = 1'b0; ro_mode = 1;
        do_eval(ch, wl, mid_j, dj, ob, bb, r, t);
        er = ordered_resp();
        total++; if (r !== er) begin bad++; $display("FAIL ordered_resp ch=%h got=%h exp=%h", ch, r, er); end
        total++; if (t !== 4'd0) begin bad++; $display("FAIL ordered_tie ch=%h got=%0d exp=0", ch, t); end
        total++; if (ob !== 0) begin bad++; $display("FAIL ordered_osc_en ch=%h bad_cycles=%0d exp=0", ch, ob); end
        total++; if (bb !== 0) begin bad++; $display("FAIL ordered_busy ch=%h bad_cycles=%0d exp=0", ch, bb); end
        total++; if (dj !== RESP_W * (wl + 4)) begin bad++; $display("FAIL ordered_done_cycle got=%0d exp=%0d", dj, RESP_W * (wl + 4)); end
        total++; if (bus1.response !== er) begin bad++; $display("FAIL ordered_hold got=%h exp=%h", bus1.response, er); end
    endtask

    task automatic test_ordered();
        check_ordered(16'hACE1, 1000, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 2; n++) begin
            logic [15:0] ch;
            ch = 16'($urandom);
            check_ordered(ch, 1000 + int'($urandom_range(0, 200)), -1);
        end
    endtask

    task automatic test_saturation();
        int dj, ob, bb; logic [7:0] r; logic [3:0] t;
        use_sat = 1'b1; ro_mode = 2;
        do_eval(16'($urandom), 200, -1, dj, ob, bb, r, t);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL sat_resp got=%h exp=00", r); end
        total++; if (t !== 4'd8) begin bad++; $display("FAIL sat_tie got=%0d exp=8", t); end
        total++; if (ob !== 0) begin bad++; $display("FAIL sat_osc_en bad_cycles=%0d exp=0", ob); end
        total++; if (dj !== 8 * 204) begin bad++; $display("FAIL sat_done_cycle got=%0d exp=%0d", dj, 8 * 204); end
        use_sat = 1'b0;
    endtask

    task automatic test_boundary();
        int dj, ob, bb; logic [7:0] r; logic [3:0] t;
        use_sat = 1'b0; ro_mode = 0;
        do_eval(16'h0000, 0, -1, dj, ob, bb, r, t);
        total++; if (dj !== 40) begin bad++; $display("FAIL bound_done_cycle got=%0d exp=40", dj); end
        total++; if (ob !== 0) begin bad++; $display("FAIL bound_osc_en bad_cycles=%0d exp=0", ob); end
        total++; if (bb !== 0) begin bad++; $display("FAIL bound_busy bad_cycles=%0d exp=0", bb); end
        total++; if (t !== 4'd8) begin bad++; $display("FAIL bound_tie got=%0d exp=8", t); end
    endtask

    task automatic test_protocol();
        int n;
        // Start pulsed mid-evaluation must be ignored.
        check_ordered(16'($urandom), 1000, 2 * 1004 + 500);

        // Start held across DONE: ignored in DONE, accepted in the following idle cycle.
        use_sat = 1'b0; ro_mode = 0;
        @(negedge clk);
        bus1.challenge = 16'h0005; bus1.window_len = 16'd2; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        n = -1;
        for (int j = 0; j < 200; j++) begin
            if (bus1.done === 1'b1) begin n = j; break; end
            @(posedge clk); #1;
        end
        total++; if (n !== 48) begin bad++; $display("FAIL proto_first_done got=%0d exp=48", n); end
        bus1.start = 1'b1;
        @(posedge clk); #1;
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL proto_start_in_done got=%b exp=0", bus1.busy); end
        @(posedge clk); #1;
        bus1.start = 1'b0;
        total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL proto_start_after_done got=%b exp=1", bus1.busy); end
        n = -1;
        for (int j = 0; j < 200; j++) begin
            if (bus1.done === 1'b1) begin n = j; break; end
            @(posedge clk); #1;
        end
        total++; if (n !== 48) begin bad++; $display("FAIL proto_second_done got=%0d exp=48", n); end

        // Reset during MEASURE of bit 3.
        ro_mode = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus1.challenge = 16'hBEEF; bus1.window_len = 16'd20; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (3 * 24 + 3 + 5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL proto_rst_busy got=%b exp=0", bus1.busy); end
        total++; if (osc_en1 !== 16'h0000) begin bad++; $display("FAIL proto_rst_osc got=%h exp=0000", osc_en1); end
        total++; if (bus1.response !== 8'h00) begin bad++; $display("FAIL proto_rst_resp got=%h exp=00", bus1.response); end
        total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL proto_rst_done got=%b exp=0", bus1.done); end
        @(negedge clk); rst_n = 1'b1;
        check_ordered(16'hACE1, 1000, -1);
    endtask

    initial begin
        test_reset();
        test_all_ties();
        test_ordered();
        test_random();
        test_saturation();
        test_boundary();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
